retire_ctrl: RTL and testbench

//  Sequences in-order retirement at ROB head; sits between ROB head and regfile/memory.
//  ALU/load results retire in the same cycle as head_valid. Stores hold the head until the memory bus accepts them.

---
 rtl/retire_ctrl.sv | 172 +++++++++++++++++
 tb/tb_retire_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_ctrl.sv
// In-order retirement sequencer at the ROB head: ALU/load retire combinationally, stores
// go through the memory bus, halt/illegal stop retirement. Optional macro: RETIRE_STORE_ACK_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif

module retire_ctrl #(
  parameter int ROB_IDX_W  = $clog2(`ROB_SZ),
  parameter int ST_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 head_valid,
  input  logic [ROB_IDX_W-1:0] head_idx,
  input  logic                 head_is_store,
  input  logic                 head_halt,
  input  logic                 head_illegal,
  input  logic [4:0]           head_dest_idx,
  input  logic [`XLEN-1:0]     head_result,
  input  logic [`XLEN-1:0]     head_NPC,
  input  logic [`XLEN-1:0]     head_st_addr,
  input  logic [`XLEN-1:0]     head_st_data,
  input  logic [1:0]           head_st_size,
  input  logic                 mem_gnt,
  input  logic [3:0]           mem2proc_response,
  input  logic [3:0]           mem2proc_tag,
  output logic                 move_head,
  output logic                 regfile_en,
  output logic [4:0]           regfile_idx,
  output logic [`XLEN-1:0]     regfile_data,
  output logic [1:0]           proc2mem_command,
  output logic [`XLEN-1:0]     proc2mem_addr,
  output logic [`XLEN-1:0]     proc2mem_data,
  output logic [1:0]           proc2mem_size,
  output logic [3:0]           completed_insts,
  output logic [`XLEN-1:0]     commit_NPC,
  output logic [3:0]           error_status,
  output logic                 flush
);
  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_STORE = 2'h2;
  localparam logic [3:0] ILLEGAL_INST  = 4'h2;
  localparam logic [3:0] NO_ERROR      = 4'ha;
  localparam logic [3:0] HALTED_ON_WFI = 4'he;
  localparam logic [7:0] TO_LAST = 8'(ST_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, ST_REQ, ST_WAIT, HALTED} state_t;

  state_t     state, next_state;
  logic [3:0] err_next;
  logic       accept;
  logic       unused_sink;

  assign accept = mem_gnt & (mem2proc_response != 4'h0);

`ifdef RETIRE_STORE_ACK_EN
  logic [3:0] tag;
  logic [7:0] timeout;
  logic       tag_ld;
  assign unused_sink = ^head_idx;
`else
  assign unused_sink = ^{head_idx, mem2proc_tag, TO_LAST};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      error_status <= NO_ERROR;
    end else begin
      state        <= next_state;
      error_status <= err_next;
    end
  end

`ifdef RETIRE_STORE_ACK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag     <= 4'h0;
      timeout <= 8'h0;
    end else if (tag_ld) begin
      tag     <= mem2proc_response;
      timeout <= 8'h0;
    end else if (state == ST_WAIT) begin
      timeout <= timeout + 8'h1;
    end
  end
`endif

  // Outputs are forced low while reset is held so an async reset silences the bus at once.
  always_comb begin
    next_state       = state;
    err_next         = error_status;
    move_head        = 1'b0;
    regfile_en       = 1'b0;
    regfile_idx      = 5'h0;
    regfile_data     = '0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = 2'h0;
    completed_insts  = 4'h0;
    commit_NPC       = '0;
    flush            = 1'b0;
`ifdef RETIRE_STORE_ACK_EN
    tag_ld           = 1'b0;
`endif
    if (!reset) begin
      case (state)
        RUN: begin
          if (head_valid) begin
            if (head_halt | head_illegal) begin
              move_head       = 1'b1;
              completed_insts = 4'h1;
              commit_NPC      = head_NPC;
              flush           = 1'b1;
              err_next        = head_illegal ? ILLEGAL_INST : HALTED_ON_WFI;
              next_state      = HALTED;
            end else if (head_is_store) begin
              next_state = ST_REQ;
            end else begin
              move_head       = 1'b1;
              completed_insts = 4'h1;
              commit_NPC      = head_NPC;
              regfile_en      = (head_dest_idx != 5'h0);
              regfile_idx     = head_dest_idx;
              regfile_data    = head_result;
            end
          end
        end
        ST_REQ: begin
          if (!head_valid) begin
            next_state = RUN;
          end else begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = head_st_addr;
            proc2mem_data    = head_st_data;
            proc2mem_size    = head_st_size;
            if (accept) begin
`ifdef RETIRE_STORE_ACK_EN
              tag_ld     = 1'b1;
              next_state = ST_WAIT;
`else
              move_head       = 1'b1;
              completed_insts = 4'h1;
              commit_NPC      = head_NPC;
              next_state      = RUN;
`endif
            end
          end
        end
`ifdef RETIRE_STORE_ACK_EN
        ST_WAIT: begin
          // A matching completion beats the timeout on the same cycle.
          if (mem2proc_tag != 4'h0 && mem2proc_tag == tag) begin
            move_head       = 1'b1;
            completed_insts = 4'h1;
            commit_NPC      = head_NPC;
            next_state      = RUN;
          end else if (timeout == TO_LAST) begin
            next_state = ST_REQ;
          end
        end
`endif
        HALTED: ;
        default: next_state = RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_retire_ctrl.sv
// Directed bench for retire_ctrl: ALU/x0 retire, store handshake, halt/illegal, timeout, async reset.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SZ
`define ROB_SZ 32
`endif

module tb_retire_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic head_valid, head_is_store, head_halt, head_illegal, mem_gnt;
  logic [$clog2(`ROB_SZ)-1:0] head_idx;
  logic [4:0] head_dest_idx;
  logic [`XLEN-1:0] head_result, head_NPC, head_st_addr, head_st_data;
  logic [1:0] head_st_size;
  logic [3:0] mem2proc_response, mem2proc_tag;
  logic move_head, regfile_en, flush;
  logic [4:0] regfile_idx;
  logic [`XLEN-1:0] regfile_data, proc2mem_addr, proc2mem_data, commit_NPC;
  logic [1:0] proc2mem_command, proc2mem_size;
  logic [3:0] completed_insts, error_status;

  int checks = 0;
  int errors = 0;

  retire_ctrl #(.ST_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .head_valid(head_valid), .head_idx(head_idx),
    .head_is_store(head_is_store), .head_halt(head_halt), .head_illegal(head_illegal),
    .head_dest_idx(head_dest_idx), .head_result(head_result), .head_NPC(head_NPC),
    .head_st_addr(head_st_addr), .head_st_data(head_st_data), .head_st_size(head_st_size),
    .mem_gnt(mem_gnt), .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .move_head(move_head), .regfile_en(regfile_en), .regfile_idx(regfile_idx),
    .regfile_data(regfile_data), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .proc2mem_size(proc2mem_size), .completed_insts(completed_insts),
    .commit_NPC(commit_NPC), .error_status(error_status), .flush(flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1, checks run at posedge+3.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle;
    head_valid = 0; head_is_store = 0; head_halt = 0; head_illegal = 0;
    mem_gnt = 0; mem2proc_response = 0; mem2proc_tag = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    tick;
    reset = 0;
  endtask

  task automatic store_head;
    head_valid = 1; head_is_store = 1; head_halt = 0; head_illegal = 0;
    head_dest_idx = 5'd7; head_NPC = 32'h40; head_st_addr = 32'h1000;
    head_st_data = 32'hdead_beef; head_st_size = 2'd2;
  endtask

  initial begin
    idle;
    reset = 1; head_idx = '0;
    head_dest_idx = 5'd4; head_result = 32'd5; head_NPC = 32'd8;
    head_st_addr = '0; head_st_data = '0; head_st_size = '0;
    head_valid = 1;
    #3;
    chk("rst_move", move_head, 0);
    chk("rst_rfen", regfile_en, 0);
    chk("rst_cmd", proc2mem_command, 0);
    chk("rst_cmpl", completed_insts, 0);
    chk("rst_err", error_status, 4'ha);
    chk("rst_flush", flush, 0);
    tick;
    reset = 0;

    // ALU retire, zero latency
    head_valid = 1; head_dest_idx = 5'd4; head_result = 32'd5; head_NPC = 32'd8;
    settle;
    chk("alu_move", move_head, 1);
    chk("alu_rfen", regfile_en, 1);
    chk("alu_idx", regfile_idx, 4);
    chk("alu_data", regfile_data, 5);
    chk("alu_npc", commit_NPC, 8);
    chk("alu_cmpl", completed_insts, 1);
    tick;
    head_dest_idx = 5'd0; head_result = 32'h77; head_NPC = 32'hc;
    settle;
    chk("x0_move", move_head, 1);
    chk("x0_rfen", regfile_en, 0);
    chk("x0_cmpl", completed_insts, 1);
    tick;
    idle;
    settle;
    chk("idle_move", move_head, 0);
    tick;

    // Store: two denied cycles, accept on the third
    store_head;
    settle;
    chk("st0_move", move_head, 0);
    chk("st0_cmd", proc2mem_command, 0);
    tick;
    settle;
    chk("st1_cmd", proc2mem_command, 2);
    chk("st1_addr", proc2mem_addr, 32'h1000);
    chk("st1_data", proc2mem_data, 32'hdead_beef);
    chk("st1_size", proc2mem_size, 2);
    chk("st1_move", move_head, 0);
    tick;
    settle;
    chk("st2_cmd", proc2mem_command, 2);
    tick;
    mem_gnt = 1; mem2proc_response = 4'd3;
    settle;
    chk("st3_cmd", proc2mem_command, 2);
`ifdef RETIRE_STORE_ACK_EN
    chk("st3_move", move_head, 0);
    tick;
    mem_gnt = 0; mem2proc_response = 0; mem2proc_tag = 4'd5;
    settle;
    chk("st4_cmd", proc2mem_command, 0);
    chk("st4_move", move_head, 0);
    tick;
    mem2proc_tag = 4'd3;
    settle;
    chk("st5_move", move_head, 1);
    chk("st5_cmpl", completed_insts, 1);
    chk("st5_rfen", regfile_en, 0);
    chk("st5_npc", commit_NPC, 32'h40);
    tick;
`else
    chk("st3_move", move_head, 1);
    chk("st3_cmpl", completed_insts, 1);
    chk("st3_rfen", regfile_en, 0);
    tick;
`endif
    idle;
    settle;
    chk("st_done_cmd", proc2mem_command, 0);
    chk("st_done_move", move_head, 0);
    tick;

`ifdef RETIRE_STORE_ACK_EN
    // Timeout re-issue after 4 ST_WAIT cycles, then async reset in ST_WAIT
    store_head;
    tick;
    mem_gnt = 1; mem2proc_response = 4'd2;
    settle;
    chk("to_req_cmd", proc2mem_command, 2);
    tick;
    mem_gnt = 0; mem2proc_response = 0;
    for (int i = 0; i < 4; i++) begin
      settle;
      chk("to_wait_cmd", proc2mem_command, 0);
      tick;
    end
    settle;
    chk("to_reissue_cmd", proc2mem_command, 2);
    mem_gnt = 1; mem2proc_response = 4'd7;
    tick;
    mem_gnt = 0; mem2proc_response = 0;
    settle;
    chk("to_wait2_cmd", proc2mem_command, 0);
    reset = 1;
    #1;
    chk("arst_wait_move", move_head, 0);
    chk("arst_wait_cmd", proc2mem_command, 0);
    tick;
    reset = 0;
    settle;
    chk("arst_run_move", move_head, 0);
    tick;
    idle;
    tick;
`endif

    // Async reset while a store is requesting
    store_head;
    tick;
    settle;
    chk("arst_req_pre", proc2mem_command, 2);
    reset = 1;
    #1;
    chk("arst_req_cmd", proc2mem_command, 0);
    chk("arst_req_move", move_head, 0);
    tick;
    reset = 0;
    idle;
    tick;

    // Halt, then ignore further heads
    head_valid = 1; head_halt = 1; head_dest_idx = 5'd4; head_NPC = 32'h80;
    settle;
    chk("halt_move", move_head, 1);
    chk("halt_flush", flush, 1);
    chk("halt_rfen", regfile_en, 0);
    chk("halt_cmpl", completed_insts, 1);
    tick;
    head_halt = 0;
    settle;
    chk("halt_err", error_status, 4'he);
    chk("halted_move", move_head, 0);
    chk("halted_rfen", regfile_en, 0);
    chk("halted_flush", flush, 0);
    tick;
    settle;
    chk("halt_err_held", error_status, 4'he);
    idle;
    do_reset;
    settle;
    chk("err_cleared", error_status, 4'ha);

    // Illegal wins over halt
    head_valid = 1; head_halt = 1; head_illegal = 1;
    settle;
    chk("ill_flush", flush, 1);
    tick;
    idle;
    settle;
    chk("ill_err", error_status, 4'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "bench timed out");
  end
endmodule
